mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the 8-bit RISC CPU bus. It serves the controller's `rd`/`wr`/`data_e` strobes against a 32×8 synchronous array. Each read returns registered data one cycle after the strobe, and each write commits once per `wr` assertion. It sits between the CPU address mux and data bus. It also provides a backdoor port used to load programs before the CPU runs.

## Interface
Parameters:
- `AWIDTH`, 5, address width.
- `DWIDTH`, 8, data width.
- `DEPTH`, 32, number of words (must equal 2**AWIDTH).
- `PROT_TOP`, 15, highest write-protected address. Used only with `MEM_RESPONDER_WPROT_EN`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset. Asynchronous assert, active-low.
- `addr`  in  AWIDTH  bus address (PC or IR operand, already muxed).
- `rd`  in  1  read strobe from the controller.
- `wr`  in  1  write strobe from the controller.
- `data_e`  in  1  CPU is driving write data.
- `wdata`  in  DWIDTH  CPU write data (accumulator).
- `rdata`  out  DWIDTH  registered read data.
- `rvalid`  out  1  `rdata` is valid for the current read.
- `busy`  out  1  write commit in progress.
- `err`  out  1  sticky protocol-error flag.
- `prog_we`  in  1  backdoor write enable.
- `prog_addr`  in  AWIDTH  backdoor address.
- `prog_data`  in  DWIDTH  backdoor data.

## Operation
- State machine: IDLE, RD_DATA, WR_COMMIT. All transitions occur on `clk` rising edge. `rd_q` and `wr_q` are registered copies of the strobes, used for edge detection.
- **IDLE → RD_DATA:**
  - Condition: `rd & ~rd_q & ~wr`.
  - Actions: `rdata <= mem[addr]`, `rvalid <= 1`.
- **RD_DATA:**
  - Holds `rdata` and `rvalid` while `rd` stays high. There is no re-read, even if `addr` changes.
  - When `rd` falls: go to IDLE, `rvalid <= 0`. `rdata` keeps its last value.
- **IDLE → WR_COMMIT:**
  - Condition: `wr & ~wr_q & data_e & ~rd`.
  - Actions: `mem[addr] <= wdata`, `busy <= 1`.
  - Next cycle: WR_COMMIT → IDLE, `busy <= 0`.
  - A `wr` held high for several cycles produces exactly one write.
- **Error cases.** Each sets `err <= 1` and performs no array access:
  - `rd & wr` sampled together.
  - Rising `wr` with `data_e = 0`.
  - `prog_we` while state ≠ IDLE or while `rd | wr` is high.
- **Backdoor:** `prog_we` in IDLE with `rd = wr = 0` writes `mem[prog_addr] <= prog_data`. State does not change.
- `err` clears only on reset.
- The array is not reset. Its contents survive `rst_n`.

## Timing
- Reset values (async on `rst_n` low): state IDLE, `rdata = 0`, `rvalid = 0`, `busy = 0`, `err = 0`, `rd_q = 0`, `wr_q = 0`.
- Read latency: 1 cycle.
  - `rd` first sampled high at edge E0; `rdata` and `rvalid` are valid from E0 until `rd` falls.
  - Two-cycle fetch (`rd` high in FETCH and LOAD): IR captures `rdata` at the end of LOAD.
  - One-cycle operand fetch: `rdata` is valid during ALU_OP and stays held afterwards.
- Write: committed at the edge where rising `wr` and `data_e` are sampled. A read of the same address in the next IDLE cycle returns the new value.
- Back-to-back: a new `rd` rise is accepted in the first cycle after returning to IDLE.
- Reset mid-read or mid-write: outputs clear immediately. A write whose edge coincides with `rst_n` low is not performed.

## Configuration
- `MEM_RESPONDER_WPROT_EN` defined:
  - CPU writes to `addr <= PROT_TOP` are dropped and set `err`.
  - The FSM still passes through WR_COMMIT.
  - Backdoor writes are unaffected.
- Not defined: every address is CPU-writable and `PROT_TOP` is ignored.

## Test plan
- Backdoor load: `prog_we` with `mem[3] = 8'hA5`, then `rd` high 2 cycles at `addr = 3` → `rvalid = 1` and `rdata = 8'hA5` one cycle after `rd`. After `rd` drops, `rvalid = 0` and `rdata` stays `8'hA5`.
- Store: `wr` + `data_e` for 1 cycle at `addr = 20`, `wdata = 8'h3C` → `busy = 1` for 1 cycle. A following read of `addr = 20` returns `8'h3C`.
- Held write: `wr` + `data_e` held 3 cycles with `wdata` changing `8'h11`→`8'h22` → memory holds `8'h11`. `busy` pulses once.
- Protocol errors: `rd = wr = 1` together → `err = 1`, no access. `wr` without `data_e` → `err = 1`, memory unchanged. Only reset clears `err`.
- Reset mid-read: drop `rst_n` while in RD_DATA → `rvalid = 0` and `rdata = 0` immediately. A post-reset read of the earlier-loaded address still returns the old data.
- With `MEM_RESPONDER_WPROT_EN`: CPU write `8'hFF` to `addr = 2` → `err = 1`, `mem[2]` unchanged. Write to `addr = 16` succeeds.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder for the 8-bit RISC CPU bus: 32x8 synchronous array with
// registered reads, edge-triggered writes and a backdoor load port. Define
// MEM_RESPONDER_WPROT_EN to drop CPU writes at or below PROT_TOP.
module mem_responder #(
  parameter int AWIDTH   = 5,
  parameter int DWIDTH   = 8,
  parameter int DEPTH    = 32,
  parameter int PROT_TOP = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  input  logic              data_e,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              err,
  input  logic              prog_we,
  input  logic [AWIDTH-1:0] prog_addr,
  input  logic [DWIDTH-1:0] prog_data
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_DATA   = 2'd1,
    WR_COMMIT = 2'd2
  } state_e;

  localparam logic [AWIDTH-1:0] PROT_LIM = AWIDTH'(PROT_TOP);

  logic [DWIDTH-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic              rd_q, wr_q;
  logic [DWIDTH-1:0] rdata_q;
  logic              rvalid_q, rvalid_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              rd_rise, wr_rise;
  logic              wr_nodata, prog_bad, wr_blocked;
  logic              rd_load;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wdata;

  assign rd_rise   = rd & ~rd_q;
  assign wr_rise   = wr & ~wr_q;
  assign wr_nodata = wr_rise & ~data_e;
  assign prog_bad  = prog_we & ((state_q != IDLE) | rd | wr);

`ifdef MEM_RESPONDER_WPROT_EN
  assign wr_blocked = (addr <= PROT_LIM);
`else
  logic unused_prot;
  assign wr_blocked  = 1'b0;
  assign unused_prot = ^PROT_LIM;
`endif

  always_comb begin
    state_d   = state_q;
    rvalid_d  = rvalid_q;
    busy_d    = busy_q;
    err_d     = err_q;
    rd_load   = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = wdata;

    if ((rd & wr) | wr_nodata | prog_bad) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (rd_rise && !wr) begin
          state_d  = RD_DATA;
          rvalid_d = 1'b1;
          rd_load  = 1'b1;
        end else if (wr_rise && data_e && !rd) begin
          // A protected write still walks through WR_COMMIT so bus timing is unchanged.
          state_d = WR_COMMIT;
          busy_d  = 1'b1;
          if (wr_blocked) begin
            err_d = 1'b1;
          end else begin
            mem_we = 1'b1;
          end
        end else if (prog_we && !rd && !wr) begin
          mem_we    = 1'b1;
          mem_waddr = prog_addr;
          mem_wdata = prog_data;
        end
      end
      RD_DATA: begin
        if (!rd) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
        end
      end
      WR_COMMIT: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The array sits outside the reset branch: its contents survive rst_n, and a
  // write whose edge sees rst_n low is simply not taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd;
      wr_q     <= wr;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      if (rd_load) begin
        rdata_q <= mem[addr];
      end
      if (mem_we) begin
        mem[mem_waddr] <= mem_wdata;
      end
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign busy   = busy_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: backdoor load, reads, writes, protocol
// errors and reset behaviour, checked with immediate assertions.
module tb_mem_responder;

  logic       clk;
  logic       rst_n;
  logic [4:0] addr;
  logic       rd;
  logic       wr;
  logic       data_e;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rvalid;
  logic       busy;
  logic       err;
  logic       prog_we;
  logic [4:0] prog_addr;
  logic [7:0] prog_data;

  int checks = 0;
  int errors = 0;

  mem_responder #(
    .AWIDTH(5), .DWIDTH(8), .DEPTH(32), .PROT_TOP(15)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .rd       (rd),
    .wr       (wr),
    .data_e   (data_e),
    .wdata    (wdata),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .busy     (busy),
    .err      (err),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic backdoor(input logic [4:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  // Read with rd high for one sampled edge, check, then drop rd.
  task automatic read_check(input string tag, input logic [4:0] a, input logic [7:0] exp);
    addr = a; rd = 1'b1;
    tick();
    check({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
    check({tag, "_rdata"}, {24'd0, rdata}, {24'd0, exp});
    rd = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; addr = '0; rd = 1'b0; wr = 1'b0; data_e = 1'b0; wdata = '0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    #12;
    check("rst_rdata",  {24'd0, rdata}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_err",    {31'd0, err}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Backdoor load then a two-cycle read
    backdoor(5'd3, 8'hA5);
    check("bd_err", {31'd0, err}, 32'd0);
    check("bd_rvalid", {31'd0, rvalid}, 32'd0);
    addr = 5'd3; rd = 1'b1;
    tick();
    check("rd1_rvalid", {31'd0, rvalid}, 32'd1);
    check("rd1_rdata", {24'd0, rdata}, 32'hA5);
    addr = 5'd7;  // no re-read while rd stays high
    tick();
    check("rd2_rvalid", {31'd0, rvalid}, 32'd1);
    check("rd2_rdata", {24'd0, rdata}, 32'hA5);
    rd = 1'b0;
    tick();
    check("rdfall_rvalid", {31'd0, rvalid}, 32'd0);
    check("rdfall_rdata", {24'd0, rdata}, 32'hA5);

    // Single-cycle store
    addr = 5'd20; wdata = 8'h3C; wr = 1'b1; data_e = 1'b1;
    tick();
    check("st_busy1", {31'd0, busy}, 32'd1);
    wr = 1'b0; data_e = 1'b0;
    tick();
    check("st_busy0", {31'd0, busy}, 32'd0);
    read_check("st_rd", 5'd20, 8'h3C);

    // Held write: only the first value lands, busy pulses once
    addr = 5'd21; wdata = 8'h11; wr = 1'b1; data_e = 1'b1;
    tick();
    check("hw_busy1", {31'd0, busy}, 32'd1);
    wdata = 8'h22;
    tick();
    check("hw_busy2", {31'd0, busy}, 32'd0);
    tick();
    check("hw_busy3", {31'd0, busy}, 32'd0);
    wr = 1'b0; data_e = 1'b0;
    tick();
    read_check("hw_rd", 5'd21, 8'h11);
    // Back-to-back: new rd rise in the first IDLE cycle
    read_check("b2b_rd", 5'd20, 8'h3C);
    check("clean_err", {31'd0, err}, 32'd0);

    // rd and wr together
    addr = 5'd20; wdata = 8'hEE; rd = 1'b1; wr = 1'b1; data_e = 1'b1;
    tick();
    check("rw_err", {31'd0, err}, 32'd1);
    check("rw_rvalid", {31'd0, rvalid}, 32'd0);
    check("rw_busy", {31'd0, busy}, 32'd0);
    rd = 1'b0; wr = 1'b0; data_e = 1'b0;
    tick();
    tick();
    check("rw_err_sticky", {31'd0, err}, 32'd1);
    read_check("rw_rd", 5'd20, 8'h3C);
    do_reset();
    check("rw_err_clr", {31'd0, err}, 32'd0);
    tick();

    // wr without data_e
    addr = 5'd20; wdata = 8'h77; wr = 1'b1; data_e = 1'b0;
    tick();
    check("nd_err", {31'd0, err}, 32'd1);
    check("nd_busy", {31'd0, busy}, 32'd0);
    wr = 1'b0;
    tick();
    read_check("nd_rd", 5'd20, 8'h3C);
    do_reset();
    tick();

    // Backdoor during a read is rejected
    addr = 5'd3; rd = 1'b1; prog_we = 1'b1; prog_addr = 5'd3; prog_data = 8'h00;
    tick();
    check("pb_err", {31'd0, err}, 32'd1);
    check("pb_rdata", {24'd0, rdata}, 32'hA5);
    rd = 1'b0; prog_we = 1'b0;
    tick();
    read_check("pb_rd", 5'd3, 8'hA5);
    do_reset();
    tick();

    // Reset mid-read clears outputs without waiting for a clock edge
    addr = 5'd3; rd = 1'b1;
    tick();
    check("mr_rvalid_pre", {31'd0, rvalid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mr_rvalid", {31'd0, rvalid}, 32'd0);
    check("mr_rdata", {24'd0, rdata}, 32'd0);
    rd = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    read_check("mr_rd", 5'd3, 8'hA5);

    // Write edge under reset is not performed
    backdoor(5'd22, 8'h55);
    tick();
    rst_n = 1'b0; addr = 5'd22; wdata = 8'h99; wr = 1'b1; data_e = 1'b1;
    tick();
    check("rw_rst_busy", {31'd0, busy}, 32'd0);
    wr = 1'b0; data_e = 1'b0;
    rst_n = 1'b1;
    tick();
    read_check("rw_rst_rd", 5'd22, 8'h55);

`ifdef MEM_RESPONDER_WPROT_EN
    backdoor(5'd2, 8'h42);
    tick();
    addr = 5'd2; wdata = 8'hFF; wr = 1'b1; data_e = 1'b1;
    tick();
    check("wp_err", {31'd0, err}, 32'd1);
    check("wp_busy", {31'd0, busy}, 32'd1);
    wr = 1'b0; data_e = 1'b0;
    tick();
    read_check("wp_rd", 5'd2, 8'h42);
    addr = 5'd16; wdata = 8'h5A; wr = 1'b1; data_e = 1'b1;
    tick();
    wr = 1'b0; data_e = 1'b0;
    tick();
    read_check("wp16_rd", 5'd16, 8'h5A);
`else
    check("np_err", {31'd0, err}, 32'd0);
    addr = 5'd2; wdata = 8'hFF; wr = 1'b1; data_e = 1'b1;
    tick();
    check("np_err_after", {31'd0, err}, 32'd0);
    wr = 1'b0; data_e = 1'b0;
    tick();
    read_check("np_rd", 5'd2, 8'hFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
